mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of wait cycles allowed for mem_ready before an access aborts; legal range 2..31.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 rd_req  input  1  control-unit request for a memory read into MDR; sampled in IDLE only.
REQ-005 wr_req  input  1  control-unit request to write the MDR contents to memory; sampled in IDLE only.
REQ-006 bus_ld  input  1  control-unit request to load MDR from the bus this cycle; honoured in IDLE only.
REQ-007 mem_ready  input  1  memory handshake; read data is valid or the write is complete in the same cycle.
REQ-008 mem_rd  output  1  memory read strobe.
REQ-009 mem_wr  output  1  memory write strobe.
REQ-010 mdr_in  output  1  MDR load enable.
REQ-011 md_sel  output  1  MDR input mux select; 0 = memory data, 1 = bus data.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on successful completion.
REQ-014 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-015 The FSM SHALL have states IDLE, RD_WAIT, WR_WAIT, DONE and ERR; all outputs are decoded from the current state plus mem_ready and bus_ld only, with no input-to-output path from rd_req or wr_req.
REQ-016 IDLE: if rd_req=1, next state is RD_WAIT; else if wr_req=1, next state is WR_WAIT; else stay in IDLE. Read wins when rd_req and wr_req are both high, and the write is dropped, not queued.
REQ-017 IDLE with bus_ld=1: mdr_in=1 and md_sel=1 in that cycle, independent of rd_req and wr_req in the same cycle.
REQ-018 RD_WAIT: mem_rd=1 and md_sel=0. If mem_ready=1, then mdr_in=1 in that same cycle and next state is DONE.
REQ-019 WR_WAIT: mem_wr=1 and mdr_in=0. If mem_ready=1, next state is DONE.
REQ-020 The wait counter SHALL be cleared on entry to RD_WAIT or WR_WAIT and increment once per wait cycle without mem_ready.
REQ-021 If the wait counter equals TIMEOUT-1 and mem_ready=0, next state is ERR.
REQ-022 If mem_ready=1 in the timeout cycle, it SHALL win: the access completes normally.
REQ-023 DONE: done=1 for exactly one cycle, then unconditionally return to IDLE; requests present in DONE are ignored.
REQ-024 ERR: err=1 for exactly one cycle, then IDLE; MDR is not loaded (mdr_in=0).
REQ-025 bus_ld outside IDLE SHALL be ignored, with mdr_in=0 unless REQ-018 applies.
REQ-026 Latency: a request accepted at edge n puts the FSM in the wait state from cycle n+1. With mem_ready already high, done occurs in cycle n+2 and IDLE is reached at n+3.
REQ-027 mem_rd and mem_wr SHALL never be high in the same cycle.

Reset
REQ-028 clr=1 at a rising edge SHALL force IDLE and clear the wait counter, overriding every other input, including mid-access.
REQ-029 Reset values: mem_rd=0, mem_wr=0, mdr_in=0, md_sel=0, busy=0, done=0, err=0; an aborted access produces neither done nor err.

Structure
REQ-030 The state encoding (enumerated IDLE, RD_WAIT, WR_WAIT, DONE, ERR) and the TIMEOUT default constant SHALL reside in the shared CPU package.
REQ-031 The wait counter SHALL be a separate sub-module, wait_timer, with 5-bit count, clear and enable inputs, and a terminal-count output compared against TIMEOUT-1.

Verification
REQ-032 Read, ready after 2 wait cycles: rd_req pulse at cycle 0 -> mem_rd high cycles 1-3, mdr_in=1 and md_sel=0 in cycle 3, done in cycle 4, busy low in cycle 5.
REQ-033 Write, ready immediately: wr_req at cycle 0, mem_ready=1 -> mem_wr high in cycle 1 only, done in cycle 2, mdr_in never high.
REQ-034 Simultaneous rd_req=wr_req=1 plus bus_ld=1 in IDLE -> mdr_in=1 and md_sel=1 in cycle 0, RD_WAIT taken, mem_wr never asserted.
REQ-035 Timeout, TIMEOUT=16, mem_ready held 0 -> mem_rd high for 16 cycles, err pulse in the 17th, no done, mdr_in never high. Repeat with mem_ready=1 in the 16th wait cycle -> done, no err.
REQ-036 clr asserted during the 3rd cycle of WR_WAIT -> next cycle all outputs 0 and IDLE; a following rd_req is accepted normally.
REQ-037 Assertion checks across all tests: mem_rd and mem_wr never both high; done and err are each at most one cycle wide.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM state encoding and
// wait-timer sizing.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StWrWait,
    StDone,
    StErr
  } state_e;

  localparam int unsigned TimeoutDefault = 16;
  localparam int unsigned CountWidth     = 5;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Control-unit / memory handshake bundle for mem_access_ctrl.
// The master drives requests and mem_ready; the slave is the controller.
interface mem_access_ctrl_if;
  logic rd_req;
  logic wr_req;
  logic bus_ld;
  logic mem_ready;
  logic mem_rd;
  logic mem_wr;
  logic mdr_in;
  logic md_sel;
  logic busy;
  logic done;
  logic err;

  modport master (
    output rd_req, wr_req, bus_ld, mem_ready,
    input  mem_rd, mem_wr, mdr_in, md_sel, busy, done, err
  );

  modport slave (
    input  rd_req, wr_req, bus_ld, mem_ready,
    output mem_rd, mem_wr, mdr_in, md_sel, busy, done, err
  );
endinterface

// File: rtl/mem_access_ctrl_wait_timer.sv
// Wait-cycle counter for memory accesses; tc_o flags the last allowed wait cycle.
module wait_timer
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned Timeout = TimeoutDefault
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CountWidth-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc_o = (count_q == CountWidth'(Timeout - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: sequences MDR reads/writes against a ready
// handshake with a bounded wait and a one-cycle done/err completion pulse.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input logic               clk,
  input logic               clr,
  mem_access_ctrl_if.slave  bus
);

  state_e state_q, state_d;
  logic   waiting;
  logic   timer_clr;
  logic   timer_en;
  logic   timer_tc;

  assign waiting   = (state_q == StRdWait) || (state_q == StWrWait);
  // Holding the timer clear outside the wait states guarantees a zero count on entry.
  assign timer_clr = clr || !waiting;
  assign timer_en  = waiting && !bus.mem_ready;

  wait_timer #(
    .Timeout (TIMEOUT)
  ) u_wait_timer (
    .clk_i (clk),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_o  (timer_tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.rd_req) begin
          state_d = StRdWait;
        end else if (bus.wr_req) begin
          state_d = StWrWait;
        end
      end
      StRdWait, StWrWait: begin
        // A ready in the terminal cycle still completes the access.
        if (bus.mem_ready) begin
          state_d = StDone;
        end else if (timer_tc) begin
          state_d = StErr;
        end
      end
      StDone, StErr: state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs depend on state, mem_ready and bus_ld only; requests never reach them.
  always_comb begin
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    bus.mdr_in = 1'b0;
    bus.md_sel = 1'b0;
    bus.busy   = (state_q != StIdle);
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.mdr_in = bus.bus_ld;
        bus.md_sel = bus.bus_ld;
      end
      StRdWait: begin
        bus.mem_rd = 1'b1;
        bus.mdr_in = bus.mem_ready;
      end
      StWrWait: bus.mem_wr = 1'b1;
      StDone:   bus.done   = 1'b1;
      StErr:    bus.err    = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random traffic, all checked
// against a transaction-level reference model.
module tb_mem_access_ctrl;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic clr = 1'b1;

  mem_access_ctrl_if ifc ();

  mem_access_ctrl #(
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: which access is open (0 none, 1 read, 2 write), how long
  // it has waited, and which completion pulse is pending (0 none, 1 done, 2 err).
  int   m_acc   = 0;
  int   m_waits = 0;
  int   m_pulse = 0;
  bit   m_valid = 1'b0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  logic [63:0] h_rd, h_wr, h_mdr, h_sel, h_busy, h_done, h_err;
  int hi = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt(input logic [63:0] v, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic begin_scen();
    hi = 0;
    h_rd = '0; h_wr = '0; h_mdr = '0; h_sel = '0; h_busy = '0; h_done = '0; h_err = '0;
  endtask

  task automatic step(input logic r, input logic w, input logic b, input logic rdy,
                      input logic c);
    logic idle, e_rd, e_wr, e_mdr, e_sel, e_busy, e_done, e_err;
    @(posedge clk);
    #1;
    ifc.rd_req    = r;
    ifc.wr_req    = w;
    ifc.bus_ld    = b;
    ifc.mem_ready = rdy;
    clr           = c;
    idle   = (m_acc == 0) && (m_pulse == 0);
    e_rd   = (m_acc == 1);
    e_wr   = (m_acc == 2);
    e_mdr  = (idle && b) || ((m_acc == 1) && rdy);
    e_sel  = idle && b;
    e_busy = !idle;
    e_done = (m_pulse == 1);
    e_err  = (m_pulse == 2);
    @(negedge clk);
    if (m_valid) begin
      chk("mem_rd", 32'(ifc.mem_rd), 32'(e_rd));
      chk("mem_wr", 32'(ifc.mem_wr), 32'(e_wr));
      chk("mdr_in", 32'(ifc.mdr_in), 32'(e_mdr));
      chk("md_sel", 32'(ifc.md_sel), 32'(e_sel));
      chk("busy",   32'(ifc.busy),   32'(e_busy));
      chk("done",   32'(ifc.done),   32'(e_done));
      chk("err",    32'(ifc.err),    32'(e_err));
      chk("rd_wr_exclusive", 32'(ifc.mem_rd & ifc.mem_wr), 32'(0));
      chk("done_width", 32'(prev_done & ifc.done), 32'(0));
      chk("err_width",  32'(prev_err & ifc.err),   32'(0));
      prev_done = ifc.done;
      prev_err  = ifc.err;
    end
    if (hi < 64) begin
      h_rd[hi] = ifc.mem_rd;   h_wr[hi] = ifc.mem_wr;  h_mdr[hi] = ifc.mdr_in;
      h_sel[hi] = ifc.md_sel;  h_busy[hi] = ifc.busy;  h_done[hi] = ifc.done;
      h_err[hi] = ifc.err;
    end
    hi++;
    // Advance the model across the coming rising edge.
    if (c) begin
      m_acc = 0; m_pulse = 0; m_waits = 0; m_valid = 1'b1;
    end else if (m_pulse != 0) begin
      m_pulse = 0;
    end else if (m_acc == 0) begin
      if (r) m_acc = 1;
      else if (w) m_acc = 2;
      m_waits = 0;
    end else if (rdy) begin
      m_acc = 0; m_pulse = 1;
    end else if (m_waits == int'(TO) - 1) begin
      m_acc = 0; m_pulse = 2;
    end else begin
      m_waits++;
    end
  endtask

  initial begin
    int mode;
    logic rdy;
    ifc.rd_req = 1'b0; ifc.wr_req = 1'b0; ifc.bus_ld = 1'b0; ifc.mem_ready = 1'b0;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    begin_scen();
    step(0, 0, 0, 0, 0);
    chk("reset_outputs", 32'({h_rd[0], h_wr[0], h_mdr[0], h_sel[0], h_busy[0], h_done[0],
                              h_err[0]}), 32'(0));

    // Read, ready after two wait cycles.
    begin_scen();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rd_cycles_1_3", 32'(cnt(h_rd, 1, 3)), 32'(3));
    chk("rd_low_0_4", 32'({h_rd[0], h_rd[4]}), 32'(0));
    chk("rd_mdr_in_c3", 32'(h_mdr[3]), 32'(1));
    chk("rd_md_sel_c3", 32'(h_sel[3]), 32'(0));
    chk("rd_done_c4", 32'(h_done[4]), 32'(1));
    chk("rd_done_count", 32'(cnt(h_done, 0, 5)), 32'(1));
    chk("rd_busy_c5", 32'(h_busy[5]), 32'(0));

    // Write, ready immediately.
    begin_scen();
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("wr_c1", 32'(h_wr[1]), 32'(1));
    chk("wr_count", 32'(cnt(h_wr, 0, 3)), 32'(1));
    chk("wr_done_c2", 32'(h_done[2]), 32'(1));
    chk("wr_no_mdr", 32'(cnt(h_mdr, 0, 3)), 32'(0));
    chk("wr_busy_c3", 32'(h_busy[3]), 32'(0));

    // Read and write together with a bus load.
    begin_scen();
    step(1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("both_mdr_sel_c0", 32'({h_mdr[0], h_sel[0]}), 32'(3));
    chk("both_rd_c1", 32'(h_rd[1]), 32'(1));
    chk("both_no_wr", 32'(cnt(h_wr, 0, 3)), 32'(0));
    chk("both_done_c2", 32'(h_done[2]), 32'(1));

    // Timeout with no ready.
    begin_scen();
    step(1, 0, 0, 0, 0);
    repeat (19) step(0, 0, 0, 0, 0);
    chk("to_rd_count", 32'(cnt(h_rd, 0, 19)), 32'(16));
    chk("to_rd_c16_c17", 32'({h_rd[16], h_rd[17]}), 32'(2));
    chk("to_err_c17", 32'(h_err[17]), 32'(1));
    chk("to_err_count", 32'(cnt(h_err, 0, 19)), 32'(1));
    chk("to_no_done", 32'(cnt(h_done, 0, 19)), 32'(0));
    chk("to_no_mdr", 32'(cnt(h_mdr, 0, 19)), 32'(0));

    // Ready arriving in the last allowed wait cycle wins.
    begin_scen();
    step(1, 0, 0, 0, 0);
    for (int i = 1; i < 20; i++) step(0, 0, 0, (i == 16), 0);
    chk("tc_ready_mdr_c16", 32'(h_mdr[16]), 32'(1));
    chk("tc_ready_done_c17", 32'(h_done[17]), 32'(1));
    chk("tc_ready_no_err", 32'(cnt(h_err, 0, 19)), 32'(0));

    // Reset in the third write wait cycle, then a fresh read.
    begin_scen();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("clr_wr_c3", 32'(h_wr[3]), 32'(1));
    chk("clr_outputs_c4", 32'({h_rd[4], h_wr[4], h_mdr[4], h_sel[4], h_busy[4], h_done[4],
                               h_err[4]}), 32'(0));
    chk("clr_no_pulse", 32'(cnt(h_done, 0, 4) + cnt(h_err, 0, 4)), 32'(0));
    chk("clr_rd_c6", 32'(h_rd[6]), 32'(1));
    chk("clr_done_c7", 32'(h_done[7]), 32'(1));

    // Random traffic with varying memory responsiveness.
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) mode = int'($urandom_range(0, 2));
      case (mode)
        0:       rdy = ($urandom_range(0, 1) == 0);
        1:       rdy = ($urandom_range(0, 7) == 0);
        default: rdy = ($urandom_range(0, 49) == 0);
      endcase
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), rdy, ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
